cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that owns one common data bus (CDB) and selects, each cycle, one of several functional units (load/store unit, ALU, FPU, branch unit, …) requesting to broadcast a result. The core instantiates it twice, once for the GPR CDB and once for the FPR CDB. Its output feeds the ROB, the register-file tag match and every reservation station's wake-up logic. Units raise a request, receive a same-cycle grant, and present their registered result one cycle later. The arbiter turns that result into the broadcast `cdb_t`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting units, 2..8. It need not be a power of two.

Ports:
- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: synchronous, active-high.
- `req[N_REQ]`  `req_if`  (valid in, ready out): per-unit broadcast request and grant.
- `unit_result[N_REQ]`  input  `cdb_t`: per-unit result register. It is meaningful in the cycle after that unit's handshake. Its `valid` field is ignored.
- `cdb`  output  `cdb_t`: broadcast bus (`valid`, `tag[ROB_WIDTH]`, `data[32]`).
- `grant_idx`  output  `$clog2(N_REQ)`: index of the unit currently driving `cdb`. Debug only; X when `cdb.valid`=0.

## Operation
- State registers:
  - `rr_ptr`: highest-priority index for the current cycle.
  - `gnt_valid_q` and `gnt_idx_q`: the grant issued in the previous cycle.
- Arbitration (combinational, cycle t):
  - Scan `req[i].valid` starting at `rr_ptr` and wrapping modulo `N_REQ`. The first set index `g` wins.
  - `req[g].ready`=1. All other `ready` outputs are 0.
  - `ready` never depends on any unit's `ready`. No unit's `valid` may depend on its own `ready`.
- Handshake: a transfer occurs when `req[g].valid && req[g].ready`. Exactly zero or one handshake happens per cycle.
- Register update at the end of cycle t:
  - `gnt_valid_q` <= handshake occurred.
  - `gnt_idx_q` <= `g`.
  - `rr_ptr` <= (`g`+1) mod `N_REQ` on a handshake. Otherwise `rr_ptr` is unchanged.
- Broadcast (cycle t+1):
  - `cdb.valid` = `gnt_valid_q`.
  - `cdb.tag`/`cdb.data` = `unit_result[gnt_idx_q]`.
  - Tag/data are X when not valid. The bench must not check them then.
- A unit's `valid` may stay high across a grant for back-to-back results. Each granted cycle is a distinct broadcast.
- Simulation check: emit `$display` error if any `ready` is asserted without the matching `valid`.

## Timing
- Request-to-grant latency: 0 cycles (combinational).
- Grant-to-broadcast latency: exactly 1 cycle. `cdb` comes from registered state plus unit registers, with no combinational path from `valid`.
- Throughput: one broadcast per cycle, sustained.
- Reset:
  - `rr_ptr`=0 and `gnt_valid_q`=0, so `cdb.valid`=0 in the cycle after `reset` is sampled.
  - All `ready`=0 while `reset`=1.
- Reset mid-operation: a grant issued in the same cycle `reset` is high is dropped. No broadcast follows it.
- No requests: `cdb.valid`=0 next cycle and `rr_ptr` holds.
- Wrap-around: `rr_ptr` = `N_REQ`-1 with a grant goes to 0. For non-power-of-two `N_REQ`, `rr_ptr` never holds an index ≥ `N_REQ`.
- Fairness: a continuously requesting unit is granted within `N_REQ` cycles.

## Structure
- Shared package (`common.vh`) holds:
  - `cdb_t` and `ROB_WIDTH` (already present).
  - New constants `N_GPR_CDB_REQ` and `N_FPR_CDB_REQ` that fix the requester count and the unit-to-index mapping for each instance.
- Sub-module `rr_pick`:
  - Parameter `N`.
  - Inputs: request vector and pointer.
  - Outputs: `any` and `idx`.
  - Pure combinational rotate / find-first-set / un-rotate. It is reusable by the issue logic.
- The top level holds the three state registers, the `ready` decode and the CDB mux.

## Test plan
- Reset: hold `reset` 2 cycles with all `valid`=1. Expect all `ready`=0 and `cdb.valid`=0 throughout and one cycle after. First grant after reset goes to unit 0.
- Single unit: unit 2 `valid`=1 for 3 cycles with results tag 5/6/7 and data 0x10/0x20/0x30. Expect `ready[2]`=1 each cycle. Broadcasts are tag 5, 6, 7 on consecutive cycles, one cycle later.
- Round-robin, `N_REQ`=4: all units valid for 8 cycles. Grant order is 0,1,2,3,0,1,2,3 and `cdb` carries each unit's tag one cycle later.
- Wrap and skip: `rr_ptr`=3 with only units 1 and 3 valid. Grant 3, then 1, then 3. `rr_ptr` values observed: 0, 2, 0.
- Reset mid-operation: unit 1 granted in the same cycle `reset`=1. Expect `cdb.valid`=0 next cycle and `rr_ptr`=0.
- Non-power-of-two `N_REQ`=3: all valid for 6 cycles. Expect grants 0,1,2,0,1,2 and `rr_ptr` never reaches 3.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and per-core requester maps for the GPR and FPR result buses.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  // GPR CDB requester count and unit-to-index mapping
  localparam int N_GPR_CDB_REQ = 4;
  localparam int GPR_CDB_LSU   = 0;
  localparam int GPR_CDB_ALU0  = 1;
  localparam int GPR_CDB_ALU1  = 2;
  localparam int GPR_CDB_BRU   = 3;

  // FPR CDB requester count and unit-to-index mapping
  localparam int N_FPR_CDB_REQ = 3;
  localparam int FPR_CDB_LSU   = 0;
  localparam int FPR_CDB_FMA   = 1;
  localparam int FPR_CDB_FDIV  = 2;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Per-unit broadcast request bundle: valid/ready handshake plus each unit's registered result.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N = 4
);
  logic [N-1:0] valid;
  logic [N-1:0] ready;
  cdb_t [N-1:0] result;

  modport master (output valid, output result, input ready);
  modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping modulo N.
// Purely combinational (rotate / find-first-set / un-rotate folded into one scan); i_ptr must be < N.
module cdb_arbiter_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);
  localparam logic [IW:0] NW = N[IW:0];

  always_comb begin : p_scan
    logic [IW:0] pos;
    o_any = 1'b0;
    o_idx = '0;
    pos   = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, i_ptr} + k[IW:0];
      if (pos >= NW) pos = pos - NW;
      if (i_req[pos[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = pos[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB owner: same-cycle grant to one requester, broadcast of its result one cycle later.
// Latency 0 request-to-ready, 1 grant-to-cdb; a unit simply waits while another holds the grant.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_GPR_CDB_REQ,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  cdb_arbiter_if.slave  req,
  output cdb_t          o_cdb,
  output logic [IW-1:0] o_grant_idx
);
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("cdb_arbiter: N_REQ must be in 2..8");
  end

  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_gnt_idx;
  logic             r_gnt_valid;
  logic             w_any;
  logic             w_hs;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_ready;
  cdb_t             w_sel;

  cdb_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .i_req (req.valid),
    .i_ptr (r_rr_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Reset suppresses the grant outright so no broadcast can follow it.
  assign w_hs = w_any && !i_reset;

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_idx] = 1'b1;
  end
  assign req.ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr    <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
    end else begin
      r_gnt_valid <= w_hs;
      r_gnt_idx   <= w_idx;
      if (w_hs) r_rr_ptr <= IW'(rr_next(int'(w_idx), N_REQ));
    end
  end

  // The unit's own valid bit is ignored; the broadcast valid comes from the grant register.
  always_comb begin
    w_sel       = req.result[r_gnt_idx];
    o_cdb       = w_sel;
    o_cdb.valid = r_gnt_valid;
  end
  assign o_grant_idx = r_gnt_idx;

  always @(posedge i_clk) begin
    if (!i_reset) begin
      assert ((w_ready & ~req.valid) == '0)
        else $error("cdb_arbiter: ready asserted without matching valid");
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a 4-requester and a 3-requester instance driven by directed and random
// request patterns, compared each cycle against a modulo-arithmetic round-robin reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst3;
  cdb_arbiter_if #(.N(4)) bus4 ();
  cdb_arbiter_if #(.N(3)) bus3 ();
  cdb_t       cdb4, cdb3;
  logic [1:0] gi4, gi3;

  cdb_arbiter #(.N_REQ(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .req(bus4), .o_cdb(cdb4), .o_grant_idx(gi4)
  );
  cdb_arbiter #(.N_REQ(3)) dut3 (
    .i_clk(clk), .i_reset(rst3), .req(bus3), .o_cdb(cdb3), .o_grant_idx(gi3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = 4-requester instance, 1 = 3-requester instance
  int   m_ptr    [2];
  int   m_prev_g [2];
  logic m_prev_hs[2];
  cdb_t nxt_res  [4];

  // Per-cycle expectations and observations
  int         exp_g, exp_gi, exp_ptr;
  logic [3:0] exp_ready;
  logic       exp_vld;
  cdb_t       exp_res;
  logic [3:0] obs_ready;
  cdb_t       obs_cdb;
  int         obs_gi, obs_ptr;

  function automatic cdb_t rand_res();
    cdb_t r;
    r.valid = 1'($urandom);
    r.tag   = ROB_WIDTH'($urandom);
    r.data  = $urandom;
    return r;
  endfunction

  // One clock cycle: drive requests/results after the edge, predict, sample at the falling edge.
  task automatic tick(input int d, input logic [3:0] v, input logic rst);
    int   n;
    cdb_t cur[4];
    n = (d == 0) ? 4 : 3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cur[i]     = nxt_res[i];
      nxt_res[i] = rand_res();
    end
    if (d == 0) begin
      rst4 = rst;
      bus4.valid = v;
      for (int i = 0; i < 4; i++) bus4.result[i] = cur[i];
    end else begin
      rst3 = rst;
      bus3.valid = v[2:0];
      for (int i = 0; i < 3; i++) bus3.result[i] = cur[i];
    end
    exp_vld = m_prev_hs[d];
    exp_gi  = m_prev_g[d];
    exp_res = exp_vld ? cur[exp_gi] : '0;
    exp_ptr = m_ptr[d];
    exp_g   = -1;
    for (int k = 0; k < n; k++)
      if (exp_g < 0 && v[(m_ptr[d] + k) % n]) exp_g = (m_ptr[d] + k) % n;
    exp_ready = '0;
    if (!rst && exp_g >= 0) exp_ready[exp_g] = 1'b1;
    m_prev_hs[d] = !rst && exp_g >= 0;
    m_prev_g[d]  = (exp_g >= 0) ? exp_g : 0;
    if (rst) m_ptr[d] = 0;
    else if (exp_g >= 0) m_ptr[d] = (exp_g + 1) % n;
    @(negedge clk);
    if (d == 0) begin
      obs_ready = bus4.ready;
      obs_cdb   = cdb4;
      obs_gi    = int'(gi4);
      obs_ptr   = int'(dut4.r_rr_ptr);
    end else begin
      obs_ready = {1'b0, bus3.ready};
      obs_cdb   = cdb3;
      obs_gi    = int'(gi3);
      obs_ptr   = int'(dut3.r_rr_ptr);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(0, 4'hF, c < 2);
      n_checks++;
      if (obs_ready !== ((c == 2) ? 4'b0001 : 4'b0000)) begin
        n_errors++; $display("FAIL reset_ready c%0d: got %b want %b", c, obs_ready, (c == 2) ? 4'b0001 : 4'b0000);
      end
      n_checks++;
      if (obs_cdb.valid !== 1'b0) begin
        n_errors++; $display("FAIL reset_cdb_valid c%0d: got %b want 0", c, obs_cdb.valid);
      end
      n_checks++;
      if (obs_ptr !== 0) begin
        n_errors++; $display("FAIL reset_ptr c%0d: got %0d want 0", c, obs_ptr);
      end
    end
  endtask

  task automatic test_single_unit();
    logic [5:0]  tags[3];
    logic [31:0] dats[3];
    tags = '{6'd5, 6'd6, 6'd7};
    dats = '{32'h10, 32'h20, 32'h30};
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) nxt_res[2] = '{valid: 1'b0, tag: tags[c-1], data: dats[c-1]};
      tick(0, (c < 3) ? 4'b0100 : 4'b0000, 1'b0);
      if (c < 3) begin
        n_checks++;
        if (obs_ready !== 4'b0100) begin
          n_errors++; $display("FAIL single_ready c%0d: got %b want 0100", c, obs_ready);
        end
      end
      if (c >= 1) begin
        n_checks++;
        if (obs_cdb.valid !== 1'b1 || obs_cdb.tag !== tags[c-1] || obs_cdb.data !== dats[c-1]) begin
          n_errors++;
          $display("FAIL single_cdb c%0d: got v%b tag %0d data %h want v1 tag %0d data %h",
                   c, obs_cdb.valid, obs_cdb.tag, obs_cdb.data, tags[c-1], dats[c-1]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    one = 4'b0001;
    tick(0, 4'b0000, 1'b1);
    for (int c = 0; c < 9; c++) begin
      tick(0, (c < 8) ? 4'hF : 4'h0, 1'b0);
      if (c < 8) begin
        n_checks++;
        if (obs_ready !== (one << (c % 4)) || obs_ready !== exp_ready) begin
          n_errors++; $display("FAIL rr_ready c%0d: got %b want %b", c, obs_ready, one << (c % 4));
        end
      end
      if (c >= 1) begin
        n_checks++;
        if (obs_cdb.valid !== 1'b1 || obs_gi !== (c - 1) % 4 ||
            obs_cdb.tag !== exp_res.tag || obs_cdb.data !== exp_res.data) begin
          n_errors++;
          $display("FAIL rr_cdb c%0d: got v%b idx %0d tag %0d data %h want v1 idx %0d tag %0d data %h",
                   c, obs_cdb.valid, obs_gi, obs_cdb.tag, obs_cdb.data, (c - 1) % 4, exp_res.tag, exp_res.data);
        end
      end
    end
  endtask

  task automatic test_wrap_skip();
    int gnt_tab[3];
    int ptr_tab[4];
    gnt_tab = '{3, 1, 3};
    ptr_tab = '{3, 0, 2, 0};
    tick(0, 4'b0000, 1'b1);
    tick(0, 4'b0100, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick(0, (c < 3) ? 4'b1010 : 4'b0000, 1'b0);
      n_checks++;
      if (obs_ptr !== ptr_tab[c]) begin
        n_errors++; $display("FAIL wrap_ptr c%0d: got %0d want %0d", c, obs_ptr, ptr_tab[c]);
      end
      if (c < 3) begin
        n_checks++;
        if (obs_ready !== exp_ready || exp_g !== gnt_tab[c]) begin
          n_errors++; $display("FAIL wrap_grant c%0d: got %b want unit %0d", c, obs_ready, gnt_tab[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 4'b0010, 1'b0);
    tick(0, 4'b0010, 1'b1);
    n_checks++;
    if (obs_ready !== 4'b0000) begin
      n_errors++; $display("FAIL midrst_ready: got %b want 0000", obs_ready);
    end
    n_checks++;
    if (obs_cdb.valid !== 1'b1 || obs_gi !== 1 || obs_cdb.tag !== exp_res.tag) begin
      n_errors++; $display("FAIL midrst_prev_cdb: got v%b idx %0d want v1 idx 1", obs_cdb.valid, obs_gi);
    end
    tick(0, 4'b0000, 1'b0);
    n_checks++;
    if (obs_cdb.valid !== 1'b0 || obs_ptr !== 0) begin
      n_errors++; $display("FAIL midrst_after: got v%b ptr %0d want v0 ptr 0", obs_cdb.valid, obs_ptr);
    end
  endtask

  task automatic test_non_pow2();
    logic [3:0] one;
    one = 4'b0001;
    tick(1, 4'b0000, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick(1, (c < 6) ? 4'b0111 : 4'b0000, 1'b0);
      if (c < 6) begin
        n_checks++;
        if (obs_ready !== (one << (c % 3)) || obs_ready !== exp_ready) begin
          n_errors++; $display("FAIL np2_ready c%0d: got %b want %b", c, obs_ready, one << (c % 3));
        end
      end
      n_checks++;
      if (obs_ptr >= 3 || obs_ptr !== exp_ptr) begin
        n_errors++; $display("FAIL np2_ptr c%0d: got %0d want %0d", c, obs_ptr, exp_ptr);
      end
      if (c >= 1) begin
        n_checks++;
        if (obs_cdb.valid !== 1'b1 || obs_gi !== (c - 1) % 3 || obs_cdb.data !== exp_res.data) begin
          n_errors++;
          $display("FAIL np2_cdb c%0d: got v%b idx %0d data %h want v1 idx %0d data %h",
                   c, obs_cdb.valid, obs_gi, obs_cdb.data, (c - 1) % 3, exp_res.data);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 300; c++) begin
        tick(d, 4'($urandom), ($urandom_range(0, 39) == 0));
        n_checks++;
        if (obs_ready !== exp_ready || obs_cdb.valid !== exp_vld || obs_ptr !== exp_ptr) begin
          n_errors++;
          $display("FAIL rand_ctl d%0d c%0d: got rdy %b v%b ptr %0d want rdy %b v%b ptr %0d",
                   d, c, obs_ready, obs_cdb.valid, obs_ptr, exp_ready, exp_vld, exp_ptr);
        end
        if (exp_vld) begin
          n_checks++;
          if (obs_gi !== exp_gi || obs_cdb.tag !== exp_res.tag || obs_cdb.data !== exp_res.data) begin
            n_errors++;
            $display("FAIL rand_cdb d%0d c%0d: got idx %0d tag %0d data %h want idx %0d tag %0d data %h",
                     d, c, obs_gi, obs_cdb.tag, obs_cdb.data, exp_gi, exp_res.tag, exp_res.data);
          end
        end
      end
    end
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    bus4.valid = '0;
    bus3.valid = '0;
    bus4.result = '0;
    bus3.result = '0;
    for (int i = 0; i < 4; i++) nxt_res[i] = rand_res();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d]     = 0;
      m_prev_g[d]  = 0;
      m_prev_hs[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_single_unit();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
    test_non_pow2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
